// File: rtl/prefetch_pkg.sv
// rtl/prefetch_pkg.sv - shared types and helpers for the prefetch request queue
package prefetch_pkg;

   typedef logic [31:0] addr_t;

   typedef enum logic [1:0] {IDLE, ISSUE, FLUSH} pq_state_t;

   function automatic int unsigned grid_cells(input int unsigned x_size,
                                              input int unsigned y_size,
                                              input int unsigned z_size);
      return x_size * y_size * z_size;
   endfunction

   function automatic logic [15:0] sat_inc(input logic [15:0] value);
      return (value == 16'hFFFF) ? value : value + 16'd1;
   endfunction

endpackage

// File: rtl/pq_match_cam.sv
// rtl/pq_match_cam.sv - combinational match of a candidate against valid queue/history entries
module pq_match_cam
   import prefetch_pkg::*;
#(
   parameter int N = 12
) (
   input  addr_t             cand,
   input  logic [N-1:0][31:0] entries,
   input  logic [N-1:0]      valid,
   output logic              hit
);

   always_comb begin
      hit = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (valid[i] && (entries[i] == cand)) hit = 1'b1;
      end
   end

endmodule

// File: rtl/prefetch_request_queue.sv
// rtl/prefetch_request_queue.sv - filtered FIFO between the neighbour prefetcher and memory
module prefetch_request_queue
   import prefetch_pkg::*;
#(
   parameter int X_SIZE = 3,
   parameter int Y_SIZE = 3,
   parameter int Z_SIZE = 3,
   parameter int DEPTH  = 8,
   parameter int HIST   = 4
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic [31:0]              pf_addr_i,
   input  logic                     pf_valid_i,
   input  logic                     flush_i,
   output logic [31:0]              mem_addr_o,
   output logic                     mem_valid_o,
   input  logic                     mem_ready_i,
   output logic [$clog2(DEPTH):0]   count_o,
   output logic [15:0]              drop_dup_o,
   output logic [15:0]              drop_full_o,
   output logic [15:0]              drop_oob_o
);

   localparam int    PTR_W = $clog2(DEPTH);
   localparam int    N_CAM = DEPTH + HIST;
   localparam addr_t CELLS = addr_t'(grid_cells(X_SIZE, Y_SIZE, Z_SIZE));

   pq_state_t          state;
   addr_t              fifo_mem [DEPTH];
   addr_t              hist_mem [HIST];
   logic [HIST-1:0]    hist_vld;
   logic [PTR_W-1:0]   rd_ptr;
   logic [PTR_W-1:0]   wr_ptr;
   logic [PTR_W:0]     count;
   logic [PTR_W:0]     count_next;

   logic [N_CAM-1:0][31:0] cam_entries;
   logic [N_CAM-1:0]       cam_valid;
   logic                   dup;
   logic                   strobe;
   logic                   oob;
   logic                   full;
   logic                   pop;
   logic                   push;

   assign mem_valid_o = (state == ISSUE);
   assign mem_addr_o  = fifo_mem[rd_ptr];
   assign count_o     = count;

   // FIFO slot i is live when its distance from the read pointer is below the occupancy
   always_comb begin
      logic [PTR_W-1:0] offset;
      offset = '0;
      for (int i = 0; i < DEPTH; i++) begin
         offset         = PTR_W'(i) - rd_ptr;
         cam_entries[i] = fifo_mem[i];
         cam_valid[i]   = ({1'b0, offset} < count);
      end
      for (int j = 0; j < HIST; j++) begin
         cam_entries[DEPTH+j] = hist_mem[j];
         cam_valid[DEPTH+j]   = hist_vld[j];
      end
   end

   pq_match_cam #(.N(N_CAM)) u_match_cam (
      .cand    (pf_addr_i),
      .entries (cam_entries),
      .valid   (cam_valid),
      .hit     (dup)
   );

   assign strobe = pf_valid_i && !flush_i && (state != FLUSH);
   assign oob    = (pf_addr_i >= CELLS);
   assign full   = (count == (PTR_W+1)'(DEPTH));
   assign pop    = mem_valid_o && mem_ready_i && !flush_i;
   assign push   = strobe && !oob && !dup && (!full || pop);

   always_comb begin
      count_next = count;
      if (push && !pop)      count_next = count + (PTR_W+1)'(1);
      else if (pop && !push) count_next = count - (PTR_W+1)'(1);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         rd_ptr      <= '0;
         wr_ptr      <= '0;
         count       <= '0;
         hist_vld    <= '0;
         drop_dup_o  <= '0;
         drop_full_o <= '0;
         drop_oob_o  <= '0;
         for (int i = 0; i < DEPTH; i++) fifo_mem[i] <= '0;
         for (int j = 0; j < HIST; j++)  hist_mem[j] <= '0;
      end else begin
         // exactly one counter per dropped strobe, in priority order
         if (strobe && oob)
            drop_oob_o <= sat_inc(drop_oob_o);
         else if (strobe && dup)
            drop_dup_o <= sat_inc(drop_dup_o);
         else if (strobe && full && !pop)
            drop_full_o <= sat_inc(drop_full_o);

         if (flush_i) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            hist_vld <= '0;
            state    <= FLUSH;
         end else begin
            if (push) begin
               fifo_mem[wr_ptr] <= pf_addr_i;
               wr_ptr           <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
               rd_ptr      <= rd_ptr + PTR_W'(1);
               hist_mem[0] <= mem_addr_o;
               hist_vld[0] <= 1'b1;
               for (int j = 1; j < HIST; j++) begin
                  hist_mem[j] <= hist_mem[j-1];
                  hist_vld[j] <= hist_vld[j-1];
               end
            end
            count <= count_next;
            case (state)
               IDLE:    if (push) state <= ISSUE;
               ISSUE:   if (count_next == '0) state <= IDLE;
               FLUSH:   state <= IDLE;
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_prefetch_request_queue.sv
// tb/tb_prefetch_request_queue.sv - directed self-checking bench for the prefetch request queue
module tb_prefetch_request_queue;

   logic        clock = 1'b0;
   logic        reset;
   logic [31:0] pf_addr_i;
   logic        pf_valid_i;
   logic        flush_i;
   logic [31:0] mem_addr_o;
   logic        mem_valid_o;
   logic        mem_ready_i;
   logic [3:0]  count_o;
   logic [15:0] drop_dup_o;
   logic [15:0] drop_full_o;
   logic [15:0] drop_oob_o;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clock = ~clock;

   prefetch_request_queue #(
      .X_SIZE(3), .Y_SIZE(3), .Z_SIZE(3), .DEPTH(8), .HIST(4)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .pf_addr_i   (pf_addr_i),
      .pf_valid_i  (pf_valid_i),
      .flush_i     (flush_i),
      .mem_addr_o  (mem_addr_o),
      .mem_valid_o (mem_valid_o),
      .mem_ready_i (mem_ready_i),
      .count_o     (count_o),
      .drop_dup_o  (drop_dup_o),
      .drop_full_o (drop_full_o),
      .drop_oob_o  (drop_oob_o)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      pf_valid_i = 1'b0;
      pf_addr_i = '0;
      flush_i = 1'b0;
      mem_ready_i = 1'b0;
      step();
      step();
      reset = 1'b0;
   endtask

   initial begin
      int seq [5] = '{4, 3, 5, 1, 7};

      do_reset();
      check("rst_valid", mem_valid_o, 0);
      check("rst_addr", mem_addr_o, 0);
      check("rst_count", count_o, 0);
      check("rst_dup", drop_dup_o, 0);
      check("rst_full", drop_full_o, 0);
      check("rst_oob", drop_oob_o, 0);

      // back-to-back strobes with memory always ready
      mem_ready_i = 1'b1;
      for (int i = 0; i < 5; i++) begin
         pf_addr_i = seq[i];
         pf_valid_i = 1'b1;
         step();
         check($sformatf("burst_valid%0d", i), mem_valid_o, 1);
         check($sformatf("burst_addr%0d", i), mem_addr_o, seq[i]);
      end
      pf_valid_i = 1'b0;
      step();
      check("burst_drain_valid", mem_valid_o, 0);
      check("burst_drain_count", count_o, 0);
      check("burst_dup", drop_dup_o, 0);
      check("burst_full", drop_full_o, 0);
      check("burst_oob", drop_oob_o, 0);

      // duplicate of a recently issued address
      pf_addr_i = 13; pf_valid_i = 1'b1;
      step();
      check("h13_addr", mem_addr_o, 13);
      pf_valid_i = 1'b0;
      step();
      pf_addr_i = 13; pf_valid_i = 1'b1;
      step();
      check("h13_dup_cnt", drop_dup_o, 1);
      check("h13_dup_valid", mem_valid_o, 0);
      pf_addr_i = 22;
      step();
      check("h22_valid", mem_valid_o, 1);
      check("h22_addr", mem_addr_o, 22);
      pf_valid_i = 1'b0;
      step();
      check("h22_drain", mem_valid_o, 0);

      // overflow with memory stalled
      do_reset();
      mem_ready_i = 1'b0;
      for (int i = 0; i < 9; i++) begin
         pf_addr_i = i;
         pf_valid_i = 1'b1;
         step();
      end
      check("ovf_count", count_o, 8);
      check("ovf_full_cnt", drop_full_o, 1);
      check("ovf_head", mem_addr_o, 0);
      check("ovf_stable_valid", mem_valid_o, 1);
      // pop and push together while full keeps occupancy at DEPTH
      pf_addr_i = 9; mem_ready_i = 1'b1;
      step();
      check("ovf_pp_count", count_o, 8);
      check("ovf_pp_full_cnt", drop_full_o, 1);
      pf_valid_i = 1'b0;
      for (int i = 1; i <= 8; i++) begin
         check($sformatf("ovf_drain%0d", i), mem_addr_o, (i == 8) ? 9 : i);
         step();
      end
      check("ovf_empty_valid", mem_valid_o, 0);
      check("ovf_empty_count", count_o, 0);
      check("ovf_dup", drop_dup_o, 0);

      // out-of-grid addresses
      pf_valid_i = 1'b1;
      pf_addr_i = 27;
      step();
      pf_addr_i = 40;
      step();
      pf_valid_i = 1'b0;
      check("oob_cnt", drop_oob_o, 2);
      check("oob_valid", mem_valid_o, 0);
      check("oob_count", count_o, 0);

      // flush with entries queued, then history cleared
      mem_ready_i = 1'b0;
      pf_valid_i = 1'b1;
      for (int i = 10; i <= 12; i++) begin
         pf_addr_i = i;
         step();
      end
      check("fl_pre_count", count_o, 3);
      pf_addr_i = 11;
      step();
      check("fl_fifo_dup", drop_dup_o, 1);
      check("fl_fifo_dup_count", count_o, 3);
      pf_valid_i = 1'b0; flush_i = 1'b1;
      step();
      flush_i = 1'b0;
      check("fl_count", count_o, 0);
      check("fl_valid", mem_valid_o, 0);
      pf_valid_i = 1'b1; pf_addr_i = 200;
      step();
      check("fl_discard_oob", drop_oob_o, 2);
      check("fl_discard_count", count_o, 0);
      pf_addr_i = 7; mem_ready_i = 1'b1;
      step();
      check("fl_reissue_valid", mem_valid_o, 1);
      check("fl_reissue_addr", mem_addr_o, 7);
      check("fl_reissue_dup", drop_dup_o, 1);
      pf_valid_i = 1'b0;
      step();

      // asynchronous reset between edges
      mem_ready_i = 1'b0;
      pf_valid_i = 1'b1;
      for (int i = 1; i <= 3; i++) begin
         pf_addr_i = i;
         step();
      end
      pf_valid_i = 1'b0;
      check("ar_pre_count", count_o, 3);
      #3;
      reset = 1'b1;
      #1;
      check("ar_valid", mem_valid_o, 0);
      check("ar_count", count_o, 0);
      check("ar_dup", drop_dup_o, 0);
      check("ar_full", drop_full_o, 0);
      check("ar_oob", drop_oob_o, 0);
      reset = 1'b0;
      step();
      pf_addr_i = 5; pf_valid_i = 1'b1; mem_ready_i = 1'b1;
      step();
      check("ar_post_valid", mem_valid_o, 1);
      check("ar_post_addr", mem_addr_o, 5);
      pf_valid_i = 1'b0;
      step();
      check("ar_post_drain", mem_valid_o, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
